// File: rtl/checkout_totalizer.sv
// checkout_totalizer: checkout session controller that accepts priced items,
// applies the expiry discount policy, and accumulates a saturating bill.
module checkout_totalizer #(
  parameter int TOTAL_W   = 8,
  parameter int CNT_W     = 5,
  parameter int MAX_ITEMS = 16
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               en,
  input  logic               start,
  input  logic               close,
  input  logic               item_valid,
  input  logic [3:0]         P,
  input  logic [1:0]         V,
  input  logic [11:0]        QR,
  output logic               item_ready,
  output logic [TOTAL_W-1:0] total,
  output logic [CNT_W-1:0]   n_ok,
  output logic [CNT_W-1:0]   n_rej,
  output logic [2:0]         last_code,
  output logic               full,
  output logic               sat,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [TOTAL_W-1:0] total_r;
  logic [CNT_W-1:0]   n_ok_r;
  logic [CNT_W-1:0]   n_rej_r;
  logic [2:0]         last_code_r;
  logic               full_r;
  logic               sat_r;
  logic               done_r;
  logic               item_ready_r;

  logic               good_s;
  logic               room_s;
  logic [3:0]         add_s;
  logic [TOTAL_W:0]   sum_s;
  logic               unused_s;

  // Worth of the presented item and the widened sum used for saturation
  always_comb begin
    good_s = (V == 2'b01) || (V == 2'b10);
    room_s = (n_ok_r != CNT_W'(MAX_ITEMS));
    if (V == 2'b10) begin
      add_s = {1'b0, P[3:1]};
    end else begin
      add_s = P;
    end
    sum_s = {1'b0, total_r} + (TOTAL_W+1)'(add_s);
  end

  // Only the product code field of the lookup word matters here
  assign unused_s = &{1'b0, QR[11:3]};

  // Session FSM with registered Moore outputs; en=0 freezes everything
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r      <= IDLE;
      total_r      <= {TOTAL_W{1'b0}};
      n_ok_r       <= {CNT_W{1'b0}};
      n_rej_r      <= {CNT_W{1'b0}};
      last_code_r  <= 3'd0;
      full_r       <= 1'b0;
      sat_r        <= 1'b0;
      done_r       <= 1'b0;
      item_ready_r <= 1'b0;
    end else if (en) begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r      <= OPEN;
            total_r      <= {TOTAL_W{1'b0}};
            n_ok_r       <= {CNT_W{1'b0}};
            n_rej_r      <= {CNT_W{1'b0}};
            last_code_r  <= 3'd0;
            full_r       <= 1'b0;
            sat_r        <= 1'b0;
            item_ready_r <= 1'b1;
          end
        end
        OPEN: begin
          if (item_valid) begin
            if (good_s && room_s) begin
              n_ok_r      <= n_ok_r + CNT_W'(1);
              full_r      <= ((n_ok_r + CNT_W'(1)) == CNT_W'(MAX_ITEMS));
              last_code_r <= QR[2:0];
              if (sum_s[TOTAL_W]) begin
                total_r <= {TOTAL_W{1'b1}};
                sat_r   <= 1'b1;
              end else begin
                total_r <= sum_s[TOTAL_W-1:0];
              end
            end else if (n_rej_r != {CNT_W{1'b1}}) begin
              n_rej_r <= n_rej_r + CNT_W'(1);
            end
          end
          // A same-cycle item has already been folded in above
          if (close) begin
            state_r      <= DONE;
            item_ready_r <= 1'b0;
            done_r       <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r      <= IDLE;
          done_r       <= 1'b0;
          item_ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign item_ready = item_ready_r;
  assign total      = total_r;
  assign n_ok       = n_ok_r;
  assign n_rej      = n_rej_r;
  assign last_code  = last_code_r;
  assign full       = full_r;
  assign sat        = sat_r;
  assign done       = done_r;

endmodule
